beam_power_integrator: RTL

- Downstream of the 4-channel complex steering multiply/sum stage. Consumes its beamformed sample (I_y, Q_y).
- Computes instantaneous power |y|^2 = I^2 + Q^2 per sample and integrates it over N_INTEGRATE valid samples (integrate-and-dump).
- Each dump produces one beam power value, tagged with a beam index that advances across a steering sweep.
- Output uses a valid/ready handshake toward the DoA peak-search / host readout logic.

---
 rtl/beam_power_if.sv | 36 +++
 rtl/beam_power_integrator.sv | 113 +++++++++++
 2 files changed

// File: rtl/beam_power_if.sv
// Handshake/data bundle between the steering-sum stage, the power integrator
// and the peak-search/readout consumer. Widths are derived here so that every
// endpoint sees the same result and beam-index sizes.
interface beam_power_if #(
  parameter int Y_WORD_LENGTH = 24,
  parameter int N_INTEGRATE   = 256,
  parameter int NUM_BEAMS     = 16
);
  localparam int PWR_W    = 2 * Y_WORD_LENGTH;
  localparam int CNT_BITS = (N_INTEGRATE > 1) ? $clog2(N_INTEGRATE) : 1;
  localparam int ACC_W    = PWR_W + CNT_BITS;
  localparam int BEAM_W   = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1;

  logic                            clear;
  logic                            in_valid;
  logic signed [Y_WORD_LENGTH-1:0] I_y;
  logic signed [Y_WORD_LENGTH-1:0] Q_y;
  logic                            out_valid;
  logic                            out_ready;
  logic        [ACC_W-1:0]         out_power;
  logic        [BEAM_W-1:0]        out_beam_idx;
  logic                            sweep_done;
  logic                            overrun;

  // Upstream sample source plus downstream consumer (drives ready).
  modport master (
    output clear, in_valid, I_y, Q_y, out_ready,
    input  out_valid, out_power, out_beam_idx, sweep_done, overrun
  );

  // The integrator itself.
  modport slave (
    input  clear, in_valid, I_y, Q_y, out_ready,
    output out_valid, out_power, out_beam_idx, sweep_done, overrun
  );
endinterface

// File: rtl/beam_power_integrator.sv
// Beam power integrator: squares each beamformed sample (I^2 + Q^2), sums the
// power over N_INTEGRATE valid samples and dumps one tagged result per beam
// through a valid/ready port. Three register stages: square, sum, accumulate.
module beam_power_integrator #(
  parameter int Y_WORD_LENGTH = 24,
  parameter int N_INTEGRATE   = 256,
  parameter int NUM_BEAMS     = 16
) (
  input  logic         clk,
  input  logic         rst,
  beam_power_if.slave  bus
);
  localparam int PWR_W    = 2 * Y_WORD_LENGTH;
  localparam int CNT_BITS = (N_INTEGRATE > 1) ? $clog2(N_INTEGRATE) : 1;
  localparam int ACC_W    = PWR_W + CNT_BITS;
  localparam int BEAM_W   = (NUM_BEAMS > 1) ? $clog2(NUM_BEAMS) : 1;

  localparam logic [CNT_BITS-1:0] CNT_LAST  = CNT_BITS'(N_INTEGRATE - 1);
  localparam logic [BEAM_W-1:0]   BEAM_LAST = BEAM_W'(NUM_BEAMS - 1);

  // Sign-extend to the full product width so the squares are exact.
  logic signed [PWR_W-1:0] i_ext, q_ext;
  logic        [PWR_W-2:0] ii_sq, qq_sq;

  assign i_ext = {{Y_WORD_LENGTH{bus.I_y[Y_WORD_LENGTH-1]}}, bus.I_y};
  assign q_ext = {{Y_WORD_LENGTH{bus.Q_y[Y_WORD_LENGTH-1]}}, bus.Q_y};
  // A square never exceeds 2^(2Y-2), so the top product bit is always zero.
  assign ii_sq = (PWR_W-1)'(i_ext * i_ext);
  assign qq_sq = (PWR_W-1)'(q_ext * q_ext);

  logic              s1_valid;
  logic [PWR_W-2:0]  s1_ii, s1_qq;
  logic              s2_valid;
  logic [PWR_W-1:0]  s2_pwr;

  logic [ACC_W-1:0]    acc;
  logic [CNT_BITS-1:0] cnt;
  logic [BEAM_W-1:0]   beam;
  logic [ACC_W-1:0]    acc_sum;
  logic                s3_take;
  logic                dump;

  assign acc_sum = acc + ACC_W'(s2_pwr);
  // clear discards whatever sits in S2 on the same edge it flushes S1/S2.
  assign s3_take = s2_valid && !bus.clear;
  assign dump    = s3_take && (cnt == CNT_LAST);

  // S1: register the two squares; a sample arriving with clear is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ii    <= '0;
      s1_qq    <= '0;
    end else begin
      s1_valid <= bus.in_valid && !bus.clear;
      s1_ii    <= ii_sq;
      s1_qq    <= qq_sq;
    end
  end

  // S2: register the instantaneous power I^2 + Q^2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pwr   <= '0;
    end else begin
      s2_valid <= s1_valid && !bus.clear;
      s2_pwr   <= PWR_W'(s1_ii) + PWR_W'(s1_qq);
    end
  end

  // S3: integrate-and-dump with sample and beam counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      beam <= '0;
    end else if (bus.clear) begin
      acc  <= '0;
      cnt  <= '0;
      beam <= '0;
    end else if (dump) begin
      acc  <= '0;
      cnt  <= '0;
      beam <= (beam == BEAM_LAST) ? '0 : beam + 1'b1;
    end else if (s3_take) begin
      acc  <= acc_sum;
      cnt  <= cnt + 1'b1;
    end
  end

  // Output register and handshake; clear leaves the presented result alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_power    <= '0;
      bus.out_beam_idx <= '0;
      bus.sweep_done   <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.sweep_done <= dump && (beam == BEAM_LAST);
      if (dump) begin
        bus.out_valid    <= 1'b1;
        bus.out_power    <= acc_sum;
        bus.out_beam_idx <= beam;
        // Overwriting a result nobody took is sticky until reset.
        if (bus.out_valid && !bus.out_ready) bus.overrun <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
